// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// status bit positions and the receive-engine state encoding.
package uart_pkg;

  localparam int unsigned REG_TXDATA = 0;
  localparam int unsigned REG_RXDATA = 1;
  localparam int unsigned REG_STATUS = 2;

  localparam int unsigned ST_TXBUSY   = 0;
  localparam int unsigned ST_RXVALID  = 1;
  localparam int unsigned ST_OVERRUN  = 2;
  localparam int unsigned ST_FRAMEERR = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receive engine: input synchronizer, mid-bit sampling FSM and shift
// register. Emits the byte with a one-cycle done or frame-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  rx_state_e        state_q, state_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             err_seen_q, err_seen_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             line, fall, tick;

  // sync_q[1] is the synchronized line; sync_q[2] is its previous value
  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      err_seen_q <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], rx_i};
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      err_seen_q <= err_seen_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    err_seen_d = err_seen_q;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = CNT_W'(CLK_DIV / 2);
        end
      end
      RX_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (line) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d    = RX_STOP;
            err_seen_d = 1'b0;
          end
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold here until the line returns high
        if (!tick)     cnt_d      = cnt_q - CNT_W'(1);
        else if (line) state_d    = RX_IDLE;
        else           err_seen_d = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    done_d = 1'b0;
    ferr_d = 1'b0;
    if (state_q == RX_STOP && tick && !err_seen_q) begin
      done_d = line;
      ferr_d = ~line;
    end
  end

  assign data_o      = shift_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: transmit engine, status/data registers and
// full 32-bit address decode around the uart_rx receive engine.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD,
  output logic        TxD,
  input  logic [31:0] inputData,
  input  logic [31:0] inputAddr,
  input  logic        wren,
  input  logic [31:0] outputAddr,
  output logic [31:0] outputData
);

  localparam int unsigned CLK_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam logic [31:0] ADDR_TX = BASE_ADDR + 32'(REG_TXDATA);
  localparam logic [31:0] ADDR_RX = BASE_ADDR + 32'(REG_RXDATA);
  localparam logic [31:0] ADDR_ST = BASE_ADDR + 32'(REG_STATUS);

  logic             txd_q, txd_d;
  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
  logic [31:0]      rdata_q, rdata_d;

  logic       wr_tx, wr_st, tx_end, tx_start;
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;
  logic       unused_wdata;

  uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (RxD),
    .data_o      (rx_byte),
    .done_o      (rx_done),
    .frame_err_o (rx_ferr)
  );

  assign unused_wdata = ^inputData[31:8];
  assign wr_tx    = wren && (inputAddr == ADDR_TX);
  assign wr_st    = wren && (inputAddr == ADDR_ST);
  assign tx_end   = tx_busy_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);
  // A write landing on the stop-bit end cycle chains straight into a new frame
  assign tx_start = wr_tx && (!tx_busy_q || tx_end);

  always_comb begin
    txd_d      = txd_q;
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_start) begin
      txd_d      = 1'b0;
      tx_busy_d  = 1'b1;
      tx_cnt_d   = CNT_W'(CLK_DIV - 1);
      tx_bit_d   = '0;
      tx_shift_d = {1'b1, inputData[7:0]};
    end else if (tx_end) begin
      txd_d     = 1'b1;
      tx_busy_d = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        txd_d      = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_cnt_d   = CNT_W'(CLK_DIV - 1);
      end else begin
        tx_cnt_d = tx_cnt_q - CNT_W'(1);
      end
    end
  end

  // Status flags: W1C clears first, then new receive events set (set wins)
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~(wr_st & inputData[ST_RXVALID]);
    overrun_d  = overrun_q  & ~(wr_st & inputData[ST_OVERRUN]);
    ferr_d     = ferr_q     & ~(wr_st & inputData[ST_FRAMEERR]);
    if (rx_done) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q) overrun_d = 1'b1;
    end
    if (rx_ferr) ferr_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (outputAddr)
      ADDR_RX: rdata_d = 32'(rx_data_q);
      ADDR_ST: begin
        rdata_d[ST_TXBUSY]   = tx_busy_q;
        rdata_d[ST_RXVALID]  = rx_valid_q;
        rdata_d[ST_OVERRUN]  = overrun_q;
        rdata_d[ST_FRAMEERR] = ferr_q;
      end
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      txd_q      <= txd_d;
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign TxD        = txd_q;
  assign outputData = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at a shortened bit time (16 clocks per bit).
module tb_uart_mmio;

  localparam logic [31:0] A_TX = 32'h0000_1000;
  localparam logic [31:0] A_RX = 32'h0000_1001;
  localparam logic [31:0] A_ST = 32'h0000_1002;
  localparam int unsigned BIT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RxD;
  logic        TxD;
  logic [31:0] inputData;
  logic [31:0] inputAddr;
  logic        wren;
  logic [31:0] outputAddr;
  logic [31:0] outputData;

  int n_vec = 0;
  int n_err = 0;

  uart_mmio #(.CLK_FREQ(160), .BAUD(10), .BASE_ADDR(32'h0000_1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD        (RxD),
    .TxD        (TxD),
    .inputData  (inputData),
    .inputAddr  (inputAddr),
    .wren       (wren),
    .outputAddr (outputAddr),
    .outputData (outputData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    outputAddr = addr;
    tick(1);
    check(tag, outputData, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    inputAddr = addr;
    inputData = data;
    wren      = 1'b1;
    tick(1);
    wren      = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick(BIT);
    end
    RxD = stop;
    tick(BIT);
    RxD = 1'b1;
  endtask

  // Called half a bit into the start bit; leaves time at mid-stop
  task automatic sample_frame(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check($sformatf("txd_%02h_bit%0d", b, i), 32'(TxD), 32'(frame[i]));
      if (i < 9) tick(BIT);
    end
  endtask

  initial begin
    rst        = 1'b1;
    RxD        = 1'b1;
    wren       = 1'b0;
    inputData  = '0;
    inputAddr  = '0;
    outputAddr = A_ST;
    tick(1);
    rst = 1'b0;
    check("reset_txd", 32'(TxD), 32'h1);
    rd(A_ST, "reset_status", 32'h0);
    rd(A_RX, "reset_rxdata", 32'h0);

    // Receive 0x05, then W1C the valid flag
    tick(2 * BIT);
    send_rx(8'h05, 1'b1);
    tick(2);
    rd(A_RX, "rx_05_data", 32'h05);
    rd(A_ST, "rx_05_status", 32'h2);
    wr(A_ST, 32'h2);
    rd(A_ST, "w1c_status", 32'h0);
    rd(A_RX, "w1c_rxdata_kept", 32'h05);
    rd(A_TX, "txdata_reads_0", 32'h0);

    // Transmit 0xA5
    wr(A_TX, 32'hA5);
    check("tx_start_low", 32'(TxD), 32'h0);
    outputAddr = A_ST;
    tick(1);
    check("tx_busy_set", outputData, 32'h1);
    tick(6);
    sample_frame(8'hA5);
    tick(6);
    check("tx_busy_stop", outputData, 32'h1);
    tick(4);
    check("tx_busy_clear", outputData, 32'h0);

    // Second write while busy is dropped
    wr(A_TX, 32'h11);
    tick(5);
    wr(A_TX, 32'h22);
    tick(1);
    sample_frame(8'h11);
    tick(10);
    check("tx11_done", outputData, 32'h0);
    tick(3 * BIT);
    check("tx_idle_after_11", 32'(TxD), 32'h1);
    check("tx_no_22_frame", outputData, 32'h0);

    // Overrun: two bytes without clearing
    send_rx(8'h05, 1'b1);
    tick(2 * BIT);
    send_rx(8'h3C, 1'b1);
    tick(2);
    rd(A_RX, "ovr_data", 32'h3C);
    rd(A_ST, "ovr_status", 32'h6);
    wr(A_ST, 32'hF);
    rd(A_ST, "ovr_cleared", 32'h0);

    // Frame error: stop bit low, byte discarded
    tick(2 * BIT);
    send_rx(8'h77, 1'b0);
    tick(8);
    rd(A_ST, "ferr_status", 32'h8);
    rd(A_RX, "ferr_data_kept", 32'h3C);
    wr(A_ST, 32'h8);
    rd(A_ST, "ferr_cleared", 32'h0);

    // Glitch on RxD shorter than half a bit
    tick(2 * BIT);
    RxD = 1'b0;
    tick(3);
    RxD = 1'b1;
    tick(3 * BIT);
    rd(A_ST, "glitch_status", 32'h0);
    send_rx(8'h05, 1'b1);
    tick(2);
    rd(A_RX, "post_glitch_data", 32'h05);
    rd(A_ST, "post_glitch_status", 32'h2);

    // Decode is exact: near-miss addresses neither read nor write
    rd(32'h0000_1003, "unmapped_read", 32'h0);
    rd(32'h0000_0002, "alias_read", 32'h0);
    wr(32'h0000_0002, 32'h2);
    rd(A_ST, "alias_write_ignored", 32'h2);

    // Reset mid-frame aborts transmission
    wr(A_TX, 32'h00);
    tick(20);
    check("txd_mid_frame", 32'(TxD), 32'h0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("txd_after_reset", 32'(TxD), 32'h1);
    rd(A_ST, "status_after_reset", 32'h0);
    tick(12 * BIT);
    check("txd_stays_idle", 32'(TxD), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
